// File: rtl/receiver.sv
// Receive endpoint: accepts packets addressed to this node's id and stores
// the payload in a small buffer indexed by the packet address. The processor
// side reads the buffer combinationally through rx_addr.

// One buffer entry: payload register plus its valid bit.
module receiver_entry #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  // Capture payload on a write; valid is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (we_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

module receiver #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] rx_in,
  input  logic [ID_WIDTH-1:0]                    id,
  output logic                                   rtr_write_enable,
  input  logic [ADDR_WIDTH-1:0]                  rx_addr,
  output logic [1:0]                             flag_res,
  output logic [DATA_WIDTH-1:0]                  data_out
);

  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

  logic [ID_WIDTH-1:0]   dest;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] payload;
  logic                  match;

  logic [NUM_ENTRIES-1:0]                 we_vec;
  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] data_all;
  logic [NUM_ENTRIES-1:0]                 valid_all;

  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] last_paddr_q, last_paddr_d;

  // Packet fields, LSB first: dest, paddr, payload.
  assign dest    = rx_in[ID_WIDTH-1:0];
  assign paddr   = rx_in[ID_WIDTH+ADDR_WIDTH-1:ID_WIDTH];
  assign payload = rx_in[ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:ID_WIDTH+ADDR_WIDTH];

  // An unknown bit in the compare yields X, which the if/&& below treat as
  // false, so a corrupted word never writes.
  assign match = (dest == id);

  // Decode the write strobe per entry.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (match && (paddr == ADDR_WIDTH'(i))) we_vec[i] = 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENTRIES; g++) begin : g_entry
      receiver_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_vec[g]),
        .data_i  (payload),
        .data_o  (data_all[g]),
        .valid_o (valid_all[g])
      );
    end
  endgenerate

  // Next-state for the write pulse and the most recently written address.
  always_comb begin
    wr_d         = 1'b0;
    last_paddr_d = last_paddr_q;
    if (match) begin
      wr_d         = 1'b1;
      last_paddr_d = paddr;
    end
  end

  // Write pulse and last-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q         <= 1'b0;
      last_paddr_q <= '0;
    end else begin
      wr_q         <= wr_d;
      last_paddr_q <= last_paddr_d;
    end
  end

  // Side-effect-free combinational read port.
  assign rtr_write_enable = wr_q;
  assign data_out         = data_all[rx_addr];
  assign flag_res[0]      = valid_all[rx_addr];
  assign flag_res[1]      = wr_q && (last_paddr_q == rx_addr);

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] rx_in;
  logic [1:0] id;
  logic       rtr_write_enable;
  logic [1:0] rx_addr;
  logic [1:0] flag_res;
  logic [1:0] data_out;

  receiver #(2, 2, 2) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_in            (rx_in),
    .id               (id),
    .rtr_write_enable (rtr_write_enable),
    .rx_addr          (rx_addr),
    .flag_res         (flag_res),
    .data_out         (data_out)
  );

  // Period 40: posedges at 20, 60, ...; checks run in the gap after an edge.
  always #20 clk = ~clk;

  typedef struct {
    string      name;
    logic       rwe;
    logic [1:0] flag;
    logic [1:0] data;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: once the read port has settled, compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (rtr_write_enable === e.rwe && flag_res === e.flag && data_out === e.data)
          n_pass++;
        else
          $display("FAIL %s: got rwe=%b flag=%b data=%b, expected rwe=%b flag=%b data=%b",
                   e.name, rtr_write_enable, flag_res, data_out, e.rwe, e.flag, e.data);
      end
    end
  end

  task automatic check(input string name, input logic [1:0] addr,
                       input logic rwe, input logic [1:0] flag, input logic [1:0] data);
    exp_t e;
    rx_addr = addr;
    e.name = name; e.rwe = rwe; e.flag = flag; e.data = data;
    q.push_back(e);
    -> chk_ev;
    #2;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    id      = 2'b01;
    rst     = 1'b1;
    rx_addr = 2'b00;
    rx_in   = 6'b110101;  // matching word while in reset must not write

    // Reset state
    edge_step(); edge_step();
    for (int a = 0; a < 4; a++) check($sformatf("reset_a%0d", a), 2'(a), 1'b0, 2'b00, 2'b00);

    // Accept: dest 01, paddr 11, payload 00
    rst   = 1'b0;
    rx_in = 6'b001101;
    edge_step();
    check("accept_a3", 2'b11, 1'b1, 2'b11, 2'b00);
    check("accept_a0", 2'b00, 1'b1, 2'b00, 2'b00);

    // Reject: dest 10
    rx_in = 6'b111010;
    edge_step();
    check("reject_a2", 2'b10, 1'b0, 2'b00, 2'b00);
    check("reject_a3", 2'b11, 1'b0, 2'b01, 2'b00);

    // Overwrite entry 1: payload 10 then 01
    rx_in = 6'b100101;
    edge_step();
    check("ovw_first", 2'b01, 1'b1, 2'b11, 2'b10);
    rx_in = 6'b010101;
    edge_step();
    check("ovw_second", 2'b01, 1'b1, 2'b11, 2'b01);
    rx_in = 6'b111010;
    edge_step();
    check("ovw_fresh_drop", 2'b01, 1'b0, 2'b01, 2'b01);

    // Clear buffer between edges, then multi-entry fill
    rst = 1'b1; #2; rst = 1'b0;
    check("clr_a1", 2'b01, 1'b0, 2'b00, 2'b00);
    rx_in = 6'b110001; edge_step();
    rx_in = 6'b100101; edge_step();
    rx_in = 6'b011001; edge_step();
    check("multi_last_a2", 2'b10, 1'b1, 2'b11, 2'b01);
    check("multi_a0_stale", 2'b00, 1'b1, 2'b01, 2'b11);
    edge_step();  // same word held: writes again, pulse stays high
    check("held_a2", 2'b10, 1'b1, 2'b11, 2'b01);
    rx_in = 6'b111010; edge_step();
    check("multi_a0", 2'b00, 1'b0, 2'b01, 2'b11);
    check("multi_a1", 2'b01, 1'b0, 2'b01, 2'b10);
    check("multi_a2", 2'b10, 1'b0, 2'b01, 2'b01);
    check("multi_a3", 2'b11, 1'b0, 2'b00, 2'b00);

    // Mid-stream reset
    rx_in = 6'b111101;  // dest 01, paddr 11, payload 11
    edge_step();
    check("stream_a3", 2'b11, 1'b1, 2'b11, 2'b11);
    #5; rst = 1'b1;
    check("midrst_a3", 2'b11, 1'b0, 2'b00, 2'b00);
    check("midrst_a0", 2'b00, 1'b0, 2'b00, 2'b00);
    edge_step(); edge_step();
    check("rst_held_a3", 2'b11, 1'b0, 2'b00, 2'b00);
    #5; rst = 1'b0;
    check("rst_rel_a3", 2'b11, 1'b0, 2'b00, 2'b00);
    edge_step();
    check("post_rst_a3", 2'b11, 1'b1, 2'b11, 2'b11);
    rx_in = 6'b111010; edge_step();
    check("post_rst_idle", 2'b11, 1'b0, 2'b01, 2'b11);

    #5;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
